// File: rtl/cell_write_arbiter.sv
// Round-robin arbiter that pops cells from NBR_OF_PORTS input channels into a
// single registered write stage, with hold-and-retry or frame-drop handling of rejects.
module cell_write_arbiter #(
  parameter int unsigned NBR_OF_PORTS   = 4,
  parameter int unsigned PARALLEL_WIDTH = 512,
  parameter int unsigned LENGTH_WIDTH   = $clog2(PARALLEL_WIDTH) + 1,
  parameter int unsigned REJECT_MODE    = 0,
  localparam int unsigned PORT_WIDTH    = (NBR_OF_PORTS > 1) ? $clog2(NBR_OF_PORTS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NBR_OF_PORTS-1:0]                cellValid,
  input  logic [NBR_OF_PORTS*PARALLEL_WIDTH-1:0] cellData,
  input  logic [NBR_OF_PORTS*LENGTH_WIDTH-1:0]   cellLength,
  input  logic [NBR_OF_PORTS-1:0]                cellSof,
  input  logic [NBR_OF_PORTS-1:0]                cellEof,
  input  logic [NBR_OF_PORTS-1:0]                cellError,
  output logic [NBR_OF_PORTS-1:0]                cellPop,
  output logic                                   writeEnable,
  output logic [PARALLEL_WIDTH-1:0]              writeData,
  output logic [LENGTH_WIDTH-1:0]                writeLength,
  output logic [PORT_WIDTH-1:0]                  writePort,
  output logic                                   writeSof,
  output logic                                   writeEof,
  output logic                                   writeError,
  input  logic                                   writeRejected,
  output logic                                   wroteCell,
  output logic [15:0]                            dropCount
);

  logic [PORT_WIDTH-1:0]     rr_ptr;
  logic [NBR_OF_PORTS-1:0]   discard;

  logic                      slot_free;
  logic                      rej_trunc;
  logic [NBR_OF_PORTS-1:0]   eff_discard;
  logic                      hi_found;
  logic                      lo_found;
  logic [PORT_WIDTH-1:0]     hi_idx;
  logic [PORT_WIDTH-1:0]     lo_idx;
  logic                      grant;
  logic [PORT_WIDTH-1:0]     grant_idx;
  logic [PORT_WIDTH-1:0]     rr_nxt;
  logic [PARALLEL_WIDTH-1:0] sel_data;
  logic [LENGTH_WIDTH-1:0]   sel_length;
  logic                      sel_sof;
  logic                      sel_eof;
  logic                      sel_error;
  logic                      sel_discard;
  logic                      load;
  logic [NBR_OF_PORTS-1:0]   discard_nxt;

  assign wroteCell = writeEnable && !writeRejected;

  // Slot availability, truncation detection and round-robin grant.
  // hi_* searches ports at or above rr_ptr, lo_* is the wrap-around fallback.
  always_comb begin
    slot_free   = !writeEnable || wroteCell || ((REJECT_MODE != 0) && writeRejected);
    rej_trunc   = (REJECT_MODE != 0) && writeEnable && writeRejected && !writeEof;
    eff_discard = discard;
    hi_found    = 1'b0;
    lo_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    for (int unsigned p = 0; p < NBR_OF_PORTS; p++) begin
      if (rej_trunc && (writePort == PORT_WIDTH'(p))) begin
        eff_discard[p] = 1'b1;
      end
      if (cellValid[p] && !hi_found && (PORT_WIDTH'(p) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = PORT_WIDTH'(p);
      end
      if (cellValid[p] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = PORT_WIDTH'(p);
      end
    end
    grant     = slot_free && !rst && (hi_found || lo_found);
    grant_idx = hi_found ? hi_idx : lo_idx;
    rr_nxt    = (grant_idx == PORT_WIDTH'(NBR_OF_PORTS - 1)) ? '0 : grant_idx + PORT_WIDTH'(1);
  end

  // Pop strobe, granted-cell mux and discard-state update.
  always_comb begin
    cellPop     = '0;
    sel_data    = '0;
    sel_length  = '0;
    sel_sof     = 1'b0;
    sel_eof     = 1'b0;
    sel_error   = 1'b0;
    sel_discard = 1'b0;
    discard_nxt = eff_discard;
    for (int unsigned p = 0; p < NBR_OF_PORTS; p++) begin
      if (grant && (grant_idx == PORT_WIDTH'(p))) begin
        cellPop[p]  = 1'b1;
        sel_data    = cellData[p*PARALLEL_WIDTH +: PARALLEL_WIDTH];
        sel_length  = cellLength[p*LENGTH_WIDTH +: LENGTH_WIDTH];
        sel_sof     = cellSof[p];
        sel_eof     = cellEof[p];
        sel_error   = cellError[p];
        sel_discard = eff_discard[p];
        // A new frame or the end of the truncated one ends discarding.
        if (cellSof[p] || cellEof[p]) begin
          discard_nxt[p] = 1'b0;
        end
      end
    end
    load = grant && (!sel_discard || sel_sof);
  end

  // Output stage, round-robin pointer, discard flags and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      discard     <= '0;
      dropCount   <= '0;
      writeEnable <= 1'b0;
      writeData   <= '0;
      writeLength <= '0;
      writePort   <= '0;
      writeSof    <= 1'b0;
      writeEof    <= 1'b0;
      writeError  <= 1'b0;
    end else begin
      discard <= discard_nxt;
      if (grant) begin
        rr_ptr <= rr_nxt;
      end
      if (rej_trunc && (dropCount != 16'hFFFF)) begin
        dropCount <= dropCount + 16'd1;
      end
      if (slot_free) begin
        writeEnable <= load;
        if (load) begin
          writeData   <= sel_data;
          writeLength <= sel_length;
          writePort   <= grant_idx;
          writeSof    <= sel_sof;
          writeEof    <= sel_eof;
          writeError  <= sel_error;
        end
      end
    end
  end

endmodule

// File: tb/tb_cell_write_arbiter.sv
// Bench for cell_write_arbiter: one instance per reject mode, both driven by the
// same stimulus and compared every cycle against a behavioural model.
module tb_cell_write_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned PW  = 32;
  localparam int unsigned LW  = 6;
  localparam int unsigned PTW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  valid, sof, eof, err;
  logic [N*PW-1:0] data;
  logic [N*LW-1:0] len;
  logic          rej;

  logic [N-1:0]  pop0, pop1;
  logic          we0, we1, ws0, ws1, wf0, wf1, wx0, wx1, wc0, wc1;
  logic [PW-1:0] wd0, wd1;
  logic [LW-1:0] wl0, wl1;
  logic [PTW-1:0] wp0, wp1;
  logic [15:0]   dc0, dc1;

  cell_write_arbiter #(.NBR_OF_PORTS(N), .PARALLEL_WIDTH(PW), .LENGTH_WIDTH(LW), .REJECT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .cellValid(valid), .cellData(data), .cellLength(len),
    .cellSof(sof), .cellEof(eof), .cellError(err), .cellPop(pop0),
    .writeEnable(we0), .writeData(wd0), .writeLength(wl0), .writePort(wp0),
    .writeSof(ws0), .writeEof(wf0), .writeError(wx0), .writeRejected(rej),
    .wroteCell(wc0), .dropCount(dc0));

  cell_write_arbiter #(.NBR_OF_PORTS(N), .PARALLEL_WIDTH(PW), .LENGTH_WIDTH(LW), .REJECT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .cellValid(valid), .cellData(data), .cellLength(len),
    .cellSof(sof), .cellEof(eof), .cellError(err), .cellPop(pop1),
    .writeEnable(we1), .writeData(wd1), .writeLength(wl1), .writePort(wp1),
    .writeSof(ws1), .writeEof(wf1), .writeError(wx1), .writeRejected(rej),
    .wroteCell(wc1), .dropCount(dc1));

  typedef struct {
    bit          en;
    logic [PW-1:0] d;
    logic [LW-1:0] l;
    int          p;
    bit          s, f, x;
  } stage_t;

  stage_t st [2];
  int     rr [2];
  bit     disc [2][N];
  int     drops [2];
  bit     known;
  int     checks, errors;

  logic [N-1:0]  s_pop  [2];
  logic          s_we   [2];
  logic          s_wc   [2];
  int            s_port [2];
  logic [PW-1:0] s_data [2];
  logic [15:0]   s_drop [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour of one mode for the current cycle, then advance to the next edge.
  task automatic model_step(input int m);
    logic [N-1:0]  d_pop;
    logic          d_we, d_wc, d_s, d_f, d_x;
    logic [PW-1:0] d_d;
    logic [LW-1:0] d_l;
    logic [PTW-1:0] d_p;
    logic [15:0]   d_dc;
    bit            free, trunc;
    int            g;
    logic [N-1:0]  e_pop;
    if (m == 0) begin
      d_pop = pop0; d_we = we0; d_wc = wc0; d_s = ws0; d_f = wf0; d_x = wx0;
      d_d = wd0; d_l = wl0; d_p = wp0; d_dc = dc0;
    end else begin
      d_pop = pop1; d_we = we1; d_wc = wc1; d_s = ws1; d_f = wf1; d_x = wx1;
      d_d = wd1; d_l = wl1; d_p = wp1; d_dc = dc1;
    end
    s_pop[m] = d_pop; s_we[m] = d_we; s_wc[m] = d_wc; s_port[m] = int'(d_p);
    s_data[m] = d_d; s_drop[m] = d_dc;

    free  = !st[m].en || !rej || (m == 1);
    trunc = (m == 1) && st[m].en && rej && !st[m].f;
    g = -1;
    if (!rst && free) begin
      for (int i = 0; i < N; i++) begin
        int p;
        p = (rr[m] + i) % N;
        if (g < 0 && valid[p]) g = p;
      end
    end
    e_pop = (g >= 0) ? (N'(1) << g) : '0;

    if (known) begin
      chk($sformatf("m%0d_pop", m), 64'(d_pop), 64'(e_pop));
      chk($sformatf("m%0d_wrote", m), 64'(d_wc), 64'(st[m].en && !rej));
      chk($sformatf("m%0d_enable", m), 64'(d_we), 64'(st[m].en));
      chk($sformatf("m%0d_dropcount", m), 64'(d_dc), 64'(drops[m]));
      if (st[m].en) begin
        chk($sformatf("m%0d_data", m), 64'(d_d), 64'(st[m].d));
        chk($sformatf("m%0d_length", m), 64'(d_l), 64'(st[m].l));
        chk($sformatf("m%0d_port", m), 64'(d_p), 64'(st[m].p));
        chk($sformatf("m%0d_flags", m), 64'({d_s, d_f, d_x}), 64'({st[m].s, st[m].f, st[m].x}));
      end
    end

    if (rst) begin
      st[m] = '{default: 0};
      rr[m] = 0;
      drops[m] = 0;
      for (int p = 0; p < N; p++) disc[m][p] = 1'b0;
    end else begin
      if (trunc) begin
        disc[m][st[m].p] = 1'b1;
        if (drops[m] < 65535) drops[m]++;
      end
      if (free) begin
        if (g >= 0 && !(disc[m][g] && !sof[g])) begin
          st[m].en = 1'b1;
          st[m].d  = data[g*PW +: PW];
          st[m].l  = len[g*LW +: LW];
          st[m].p  = g;
          st[m].s  = sof[g];
          st[m].f  = eof[g];
          st[m].x  = err[g];
          disc[m][g] = 1'b0;
        end else begin
          if (g >= 0 && eof[g]) disc[m][g] = 1'b0;
          st[m].en = 1'b0;
        end
        if (g >= 0) rr[m] = (g + 1) % N;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step(0);
    model_step(1);
    if (rst) known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] s, input logic [N-1:0] e);
    valid = v; sof = s; eof = e;
    err = N'($urandom);
    for (int p = 0; p < N; p++) begin
      data[p*PW +: PW] = $urandom;
      len[p*LW +: LW]  = LW'($urandom);
    end
  endtask

  logic [PW-1:0] held, nf;

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; known = 1'b0;
    for (int m = 0; m < 2; m++) begin
      st[m] = '{default: 0}; rr[m] = 0; drops[m] = 0;
      for (int p = 0; p < N; p++) disc[m][p] = 1'b0;
    end
    rst = 1'b1; rej = 1'b0;
    drive(4'hF, 4'hF, 4'hF);
    #1;
    tick();
    tick();
    chk("rst_pop0", 64'(s_pop[0]), 64'h0);
    chk("rst_pop1", 64'(s_pop[1]), 64'h0);
    chk("rst_enable", 64'(s_we[1]), 64'h0);
    chk("rst_dropcount", 64'(s_drop[1]), 64'h0);

    // All ports valid, no rejects: strict rotation one cell per cycle.
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 4'hF, 4'hF);
      tick();
      chk("rr_pop", 64'(s_pop[1]), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("rr_port", 64'(s_port[1]), 64'((k - 1) % 4));
        chk("rr_wrote", 64'(s_wc[1]), 64'h1);
      end
    end

    // Hold-and-retry: port 2 cell rejected three times, accepted on the fourth offer.
    drive(4'b0100, 4'hF, 4'hF);
    held = data[2*PW +: PW];
    tick();
    chk("retry_first_pop", 64'(s_pop[0]), 64'h4);
    rej = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 4'hF, 4'hF);
      tick();
      chk("retry_pop", 64'(s_pop[0]), 64'h0);
      chk("retry_enable", 64'(s_we[0]), 64'h1);
      chk("retry_port", 64'(s_port[0]), 64'h2);
      chk("retry_data", 64'(s_data[0]), 64'(held));
      chk("retry_wrote", 64'(s_wc[0]), 64'h0);
    end
    rej = 1'b0;
    drive(4'hF, 4'hF, 4'hF);
    tick();
    chk("retry_accept", 64'(s_wc[0]), 64'h1);
    chk("retry_accept_data", 64'(s_data[0]), 64'(held));
    chk("eof_reject_dropcount", 64'(s_drop[1]), 64'h0);

    // Frame drop: port 1 four-cell frame, cell 2 rejected.
    drive(4'b0010, 4'b0010, 4'b0000); tick();
    drive(4'b0010, 4'b0000, 4'b0000); tick();
    rej = 1'b1;
    drive(4'b0010, 4'b0000, 4'b0000); tick();
    chk("trunc_drop_before", 64'(s_drop[1]), 64'h0);
    chk("trunc_pop3", 64'(s_pop[1]), 64'h2);
    rej = 1'b0;
    drive(4'b0010, 4'b0000, 4'b0010); tick();
    chk("trunc_drop_after", 64'(s_drop[1]), 64'h1);
    chk("trunc_cell3_not_offered", 64'(s_we[1]), 64'h0);
    chk("trunc_pop4", 64'(s_pop[1]), 64'h2);
    drive(4'b0010, 4'b0010, 4'b0010);
    nf = data[1*PW +: PW];
    tick();
    chk("trunc_cell4_not_offered", 64'(s_we[1]), 64'h0);
    drive(4'b0000, 4'b0000, 4'b0000); tick();
    chk("sof_enable", 64'(s_we[1]), 64'h1);
    chk("sof_data", 64'(s_data[1]), 64'(nf));
    chk("sof_port", 64'(s_port[1]), 64'h1);

    // Reset in the middle of a retry.
    drive(4'b0100, 4'hF, 4'hF); tick();
    rej = 1'b1;
    drive(4'hF, 4'hF, 4'hF); tick(); tick();
    rst = 1'b1; tick();
    chk("rst_mid_pop0", 64'(s_pop[0]), 64'h0);
    chk("rst_mid_pop1", 64'(s_pop[1]), 64'h0);
    rst = 1'b0; rej = 1'b0;
    drive(4'b1010, 4'hF, 4'hF); tick();
    chk("rst_mid_enable0", 64'(s_we[0]), 64'h0);
    chk("rst_mid_enable1", 64'(s_we[1]), 64'h0);
    chk("rst_mid_dropcount", 64'(s_drop[1]), 64'h0);
    chk("rst_mid_grant0", 64'(s_pop[0]), 64'h2);
    chk("rst_mid_grant1", 64'(s_pop[1]), 64'h2);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(99) == 0);
      rej = ($urandom_range(9) < 3);
      drive(N'($urandom), N'($urandom & $urandom), N'($urandom));
      tick();
    end

    // Drop counter saturation: one truncation per cycle on port 0.
    rst = 1'b1; rej = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000); tick();
    rst = 1'b0; rej = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      drive(4'b0001, 4'b0001, 4'b0000);
      tick();
    end
    chk("sat_dropcount", 64'(s_drop[1]), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
